input_debounce_sync: RTL and testbench

- Single-bit synchronizer and debouncer for asynchronous pad-level control inputs, e.g. the cross-correlation enable (XC_EN) before it reaches the 60 MHz processing domain.
- Brings `in` into the `clk` domain through a flop chain.
- Filters glitches shorter than a programmable stability window.
- Outputs a clean level plus single-cycle rise/fall strobes.

---
 rtl/input_debounce_sync_pkg.sv | 6 +
 rtl/input_debounce_sync_bit_sync_chain.sv | 14 +
 rtl/input_debounce_sync.sv | 43 ++++
 tb/tb_input_debounce_sync.sv | 117 +++++++++++
 4 files changed

// File: rtl/input_debounce_sync_pkg.sv
// input_debounce_sync_pkg: shared sizing helper for the debouncer
package input_debounce_sync_pkg;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/input_debounce_sync_bit_sync_chain.sv
// bit_sync_chain: multi-flop synchronizer for a single asynchronous level
module bit_sync_chain #(
  parameter int   SYNC_STAGES = 2,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);
  logic [SYNC_STAGES-1:0] s;
  always_ff @(posedge clk) s <= rst ? {SYNC_STAGES{INIT_LEVEL}} : {s[SYNC_STAGES-2:0], in};
  assign out = s[SYNC_STAGES-1];
endmodule

// File: rtl/input_debounce_sync.sv
// input_debounce_sync: synchronizes and debounces a pad level, with rise/fall strobes
module input_debounce_sync
  import input_debounce_sync_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 16,
  parameter logic INIT_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);
  localparam int CW = cnt_width(STABLE_CYCLES);
  logic          sync_in;
  logic [CW-1:0] cnt;
  logic          diff;
  logic          done;
  bit_sync_chain #(.SYNC_STAGES(SYNC_STAGES), .INIT_LEVEL(INIT_LEVEL)) u_sync (
    .clk(clk),
    .rst(rst),
    .in (in),
    .out(sync_in)
  );
  assign diff = sync_in != out;
  // counter clears on completion, so it never exceeds STABLE_CYCLES-1
  assign done = diff && cnt == CW'(STABLE_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      out  <= INIT_LEVEL;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      cnt  <= (!diff || done) ? '0 : cnt + CW'(1);
      out  <= done ? sync_in : out;
      rise <= done && sync_in;
      fall <= done && !sync_in;
    end
  end
endmodule

// File: tb/tb_input_debounce_sync.sv
// tb_input_debounce_sync: scoreboard bench; expected strobes queued by stimulus, checked by monitors
module tb_input_debounce_sync;
  typedef struct packed {logic r; int c;} ev_t;
  logic clk = 1'b0;
  logic rst0 = 1'b1, in0 = 1'b1, rst1 = 1'b1, in1 = 1'b0;
  logic out0, rise0, fall0, out1, rise1, fall1;
  int   cyc = 0, passed = 0, total = 0;
  ev_t  q0[$], q1[$];
  input_debounce_sync d0 (.clk(clk), .rst(rst0), .in(in0), .out(out0), .rise(rise0), .fall(fall0));
  input_debounce_sync #(.SYNC_STAGES(3), .STABLE_CYCLES(1), .INIT_LEVEL(1'b0)) d1 (
    .clk(clk), .rst(rst1), .in(in1), .out(out1), .rise(rise1), .fall(fall1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input bit ok, input string nm, input int act, input int exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask
  always @(negedge clk) begin
    ev_t e;
    if (rise0 || fall0) begin
      check(!(rise0 && fall0), "d0 both strobes", 1, 0);
      check(q0.size() != 0, "d0 unexpected strobe", 0, 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check(e.r == rise0, "d0 strobe kind rise", int'(rise0), int'(e.r));
        check(e.c == cyc, "d0 strobe cycle", cyc, e.c);
        check(out0 == e.r, "d0 out at strobe", int'(out0), int'(e.r));
      end
    end
    if (rise1 || fall1) begin
      check(!(rise1 && fall1), "d1 both strobes", 1, 0);
      check(q1.size() != 0, "d1 unexpected strobe", 0, 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check(e.r == rise1, "d1 strobe kind rise", int'(rise1), int'(e.r));
        check(e.c == cyc, "d1 strobe cycle", cyc, e.c);
        check(out1 == e.r, "d1 out at strobe", int'(out1), int'(e.r));
      end
    end
  end
  task automatic settle0(input int n, input logic lvl, input string nm);
    repeat (n) @(negedge clk);
    check(q0.size() == 0, {nm, " pending strobes"}, q0.size(), 0);
    check(out0 == lvl, {nm, " out level"}, int'(out0), int'(lvl));
  endtask
  task automatic settle1(input int n, input logic lvl, input string nm);
    repeat (n) @(negedge clk);
    check(q1.size() == 0, {nm, " pending strobes"}, q1.size(), 0);
    check(out1 == lvl, {nm, " out level"}, int'(out1), int'(lvl));
  endtask
  initial begin
    // reset held 3 edges with in=1; outputs must stay at init
    repeat (3) begin
      @(negedge clk);
      check(out0 == 1'b0, "reset out", int'(out0), 0);
      check(rise0 == 1'b0 && fall0 == 1'b0, "reset strobes", int'({rise0, fall0}), 0);
    end
    rst0 = 1'b0;
    q0.push_back('{1'b1, cyc + 18});
    settle0(25, 1'b1, "post-reset rise");
    in0 = 1'b0;
    q0.push_back('{1'b0, cyc + 18});
    settle0(25, 1'b0, "clean fall");
    in0 = 1'b1;
    q0.push_back('{1'b1, cyc + 18});
    settle0(25, 1'b1, "clean rise");
    in0 = 1'b0;
    q0.push_back('{1'b0, cyc + 18});
    settle0(25, 1'b0, "clean fall 2");
    in0 = 1'b1;
    repeat (10) @(negedge clk);
    in0 = 1'b0;
    settle0(30, 1'b0, "glitch 10");
    in0 = 1'b1;
    q0.push_back('{1'b1, cyc + 18});
    q0.push_back('{1'b0, cyc + 34});
    repeat (16) @(negedge clk);
    in0 = 1'b0;
    settle0(30, 1'b0, "glitch 16");
    for (int k = 0; k < 100; k++) begin
      in0 = (k % 2 == 0);
      repeat (5) @(negedge clk);
    end
    check(out0 == 1'b0, "chatter out", int'(out0), 0);
    in0 = 1'b1;
    q0.push_back('{1'b1, cyc + 18});
    settle0(25, 1'b1, "chatter settle");
    in0 = 1'b0;
    q0.push_back('{1'b0, cyc + 18});
    settle0(25, 1'b0, "chatter fall");
    in0 = 1'b1;
    repeat (12) @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    check(out0 == 1'b0, "mid-count reset out", int'(out0), 0);
    rst0 = 1'b0;
    q0.push_back('{1'b1, cyc + 18});
    settle0(25, 1'b1, "mid-count restart");
    rst1 = 1'b0;
    settle1(5, 1'b0, "d1 reset");
    in1 = 1'b1;
    q1.push_back('{1'b1, cyc + 4});
    settle1(10, 1'b1, "d1 rise");
    in1 = 1'b0;
    q1.push_back('{1'b0, cyc + 4});
    settle1(10, 1'b0, "d1 fall");
    in1 = 1'b1;
    q1.push_back('{1'b1, cyc + 4});
    q1.push_back('{1'b0, cyc + 5});
    @(negedge clk);
    in1 = 1'b0;
    settle1(10, 1'b0, "d1 pulse");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
